// File: rtl/mempool_axi_console_if.sv
// AXI slave request/response bundle for the console block.
// The struct types are supplied by whoever instantiates the bundle.
interface mempool_axi_console_if #(
  parameter type req_t  = logic,
  parameter type resp_t = logic
);
  req_t  req;
  resp_t resp;

  modport master (output req, input resp);
  modport slave (input req, output resp);
endinterface

// File: rtl/mempool_axi_console.sv
// AXI slave console: writes become characters in one shared FIFO, one address decodes to
// end-of-computation, and every read is answered with SLVERR.

typedef struct packed {
  logic [5:0]  id;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
} mempool_axi_console_ax_t;

typedef struct packed {
  logic [31:0] data;
  logic [3:0]  strb;
  logic        last;
} mempool_axi_console_w_t;

typedef struct packed {
  logic [5:0] id;
  logic [1:0] resp;
  logic       user;
} mempool_axi_console_b_t;

typedef struct packed {
  logic [5:0]  id;
  logic [31:0] data;
  logic [1:0]  resp;
  logic        last;
  logic        user;
} mempool_axi_console_r_t;

typedef struct packed {
  mempool_axi_console_ax_t aw;
  logic                    aw_valid;
  mempool_axi_console_w_t  w;
  logic                    w_valid;
  logic                    b_ready;
  mempool_axi_console_ax_t ar;
  logic                    ar_valid;
  logic                    r_ready;
} mempool_axi_console_req_t;

typedef struct packed {
  logic                   aw_ready;
  logic                   ar_ready;
  logic                   w_ready;
  logic                   b_valid;
  mempool_axi_console_b_t b;
  logic                   r_valid;
  mempool_axi_console_r_t r;
} mempool_axi_console_resp_t;

module mempool_axi_console #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdWidth       = 6,
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned CharFifoDepth = 8,
  parameter int unsigned ChanSelLsb    = 8,
  parameter logic [31:0] EocOffset     = 32'h0000_F000,
  parameter type axi_req_t             = mempool_axi_console_req_t,
  parameter type axi_resp_t            = mempool_axi_console_resp_t,
  localparam int unsigned ChanW        = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  axi_req_t         axi_req_i,
  output axi_resp_t        axi_resp_o,
  output logic             char_valid_o,
  output logic [7:0]       char_data_o,
  output logic [ChanW-1:0] char_chan_o,
  input  logic             char_ready_i,
  output logic             eoc_valid_o,
  output logic [31:0]      eoc_retval_o
);

  localparam int unsigned LaneW = $clog2(DataWidth / 8);
  localparam int unsigned OffW  = ChanSelLsb + 8;
  localparam int unsigned PtrW  = (CharFifoDepth > 1) ? $clog2(CharFifoDepth) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [OffW-1:0] EocOff = OffW'(EocOffset);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both 1;
  // a ready here never looks at the matching valid, and no valid is withdrawn before its transfer.
  logic                 active_q;
  w_state_e             w_state_q, w_state_d;
  logic [IdWidth-1:0]   w_id_q, w_id_d;
  logic [AddrWidth-1:0] w_addr_q, w_addr_d;
  logic [8:0]           w_cnt_q, w_cnt_d;
  r_state_e             r_state_q, r_state_d;
  logic [IdWidth-1:0]   r_id_q, r_id_d;
  logic [7:0]           r_cnt_q, r_cnt_d;
  logic                 eoc_valid_q, eoc_valid_d;
  logic [31:0]          eoc_retval_q, eoc_retval_d;
  logic [ChanW+7:0]     fifo_mem_q [CharFifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic fifo_full, fifo_empty, push, pop, w_hs, is_eoc;
  logic [LaneW-1:0] lane;
  logic [7:0]       w_char;
  logic [ChanW-1:0] w_chan;
  logic             unused_bits;

  assign is_eoc = (w_addr_q[OffW-1:0] == EocOff);
  assign lane   = w_addr_q[LaneW-1:0];
  assign w_char = axi_req_i.w.data[lane*8 +: 8];
  assign w_chan = (NumChannels > 1) ? w_addr_q[ChanSelLsb +: ChanW] : '0;

  assign fifo_full  = (fifo_cnt_q == CntW'(CharFifoDepth));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = !fifo_empty && char_ready_i;

  assign aw_ready = active_q && (w_state_q == W_IDLE);
  // A full FIFO still takes a console beat when the sink drains a slot in the same cycle.
  assign w_ready  = active_q && (w_state_q == W_DATA) && (is_eoc || !fifo_full || pop);
  assign b_valid  = active_q && (w_state_q == W_RESP);
  assign ar_ready = active_q && (r_state_q == R_IDLE);
  assign r_valid  = active_q && (r_state_q == R_DATA);

  assign w_hs = axi_req_i.w_valid && w_ready;
  assign push = w_hs && !is_eoc && axi_req_i.w.strb[lane];

  assign unused_bits = ^{axi_req_i, w_addr_q};

  always_comb begin
    w_state_d    = w_state_q;
    w_id_d       = w_id_q;
    w_addr_d     = w_addr_q;
    w_cnt_d      = w_cnt_q;
    eoc_valid_d  = eoc_valid_q;
    eoc_retval_d = eoc_retval_q;
    case (w_state_q)
      W_IDLE: begin
        if (axi_req_i.aw_valid && aw_ready) begin
          w_id_d    = axi_req_i.aw.id;
          w_addr_d  = axi_req_i.aw.addr;
          w_cnt_d   = 9'(axi_req_i.aw.len) + 9'd1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_cnt_d = w_cnt_q - 9'd1;
          if (axi_req_i.w.last || (w_cnt_q == 9'd1)) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_req_i.b_ready && b_valid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    // Only the first end-of-computation value is kept; later ones are acknowledged and dropped.
    if (w_hs && is_eoc && !eoc_valid_q) begin
      eoc_valid_d  = 1'b1;
      eoc_retval_d = axi_req_i.w.data[31:0];
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_cnt_d   = r_cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi_req_i.ar_valid && ar_ready) begin
          r_id_d    = axi_req_i.ar.id;
          r_cnt_d   = axi_req_i.ar.len;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi_req_i.r_ready && r_valid) begin
          if (r_cnt_q == 8'd0) r_state_d = R_IDLE;
          else                 r_cnt_d   = r_cnt_q - 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.b.id     = w_id_q;
    axi_resp_o.b.resp   = 2'b00;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.r_valid  = r_valid;
    axi_resp_o.r.id     = r_id_q;
    axi_resp_o.r.resp   = 2'b10;
    axi_resp_o.r.last   = r_valid && (r_cnt_q == 8'd0);
  end

  assign char_valid_o = !fifo_empty;
  assign char_data_o  = fifo_empty ? 8'd0 : fifo_mem_q[rd_ptr_q][7:0];
  assign char_chan_o  = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q][ChanW+7:8];
  assign eoc_valid_o  = eoc_valid_q;
  assign eoc_retval_o = eoc_retval_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q     <= 1'b0;
      w_state_q    <= W_IDLE;
      w_id_q       <= '0;
      w_addr_q     <= '0;
      w_cnt_q      <= '0;
      r_state_q    <= R_IDLE;
      r_id_q       <= '0;
      r_cnt_q      <= '0;
      eoc_valid_q  <= 1'b0;
      eoc_retval_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      active_q     <= 1'b1;
      w_state_q    <= w_state_d;
      w_id_q       <= w_id_d;
      w_addr_q     <= w_addr_d;
      w_cnt_q      <= w_cnt_d;
      r_state_q    <= r_state_d;
      r_id_q       <= r_id_d;
      r_cnt_q      <= r_cnt_d;
      eoc_valid_q  <= eoc_valid_d;
      eoc_retval_q <= eoc_retval_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {w_chan, w_char};
  end

endmodule

// File: tb/tb_mempool_axi_console.sv
// Directed bench for mempool_axi_console: console writes, bursts, backpressure, EOC,
// error reads and mid-burst reset, with a character scoreboard.
module tb_mempool_axi_console;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        char_valid_o;
  logic [7:0]  char_data_o;
  logic [1:0]  char_chan_o;
  logic        char_ready_i;
  logic        eoc_valid_o;
  logic [31:0] eoc_retval_o;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  mempool_axi_console_if #(
    .req_t (mempool_axi_console_req_t),
    .resp_t(mempool_axi_console_resp_t)
  ) axi_if ();

  mempool_axi_console dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .axi_req_i   (axi_if.req),
    .axi_resp_o  (axi_if.resp),
    .char_valid_o(char_valid_o),
    .char_data_o (char_data_o),
    .char_chan_o (char_chan_o),
    .char_ready_i(char_ready_i),
    .eoc_valid_o (eoc_valid_o),
    .eoc_retval_o(eoc_retval_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk_i) begin
    if (rst_ni && char_valid_o && char_ready_i) begin
      if (exp_q.size() == 0) begin
        check("char_extra", 32'(char_valid_o), 32'd0);
      end else begin
        check("char", 32'({6'd0, char_chan_o, char_data_o}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (start just after a rising edge) ----------------
  task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit ok = 0;
    axi_if.req.aw.id    = id;
    axi_if.req.aw.addr  = addr;
    axi_if.req.aw.len   = len;
    axi_if.req.aw.size  = 3'd2;
    axi_if.req.aw.burst = 2'd0;
    axi_if.req.aw_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (axi_if.resp.aw_ready) begin ok = 1; break; end
    end
    if (!ok) check("aw_timeout", 32'(axi_if.resp.aw_ready), 32'd1);
    @(posedge clk_i);
    #1 axi_if.req.aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit ok = 0;
    axi_if.req.w.data  = data;
    axi_if.req.w.strb  = strb;
    axi_if.req.w.last  = last;
    axi_if.req.w_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (axi_if.resp.w_ready) begin ok = 1; break; end
    end
    if (!ok) check("w_timeout", 32'(axi_if.resp.w_ready), 32'd1);
    @(posedge clk_i);
    #1 axi_if.req.w_valid = 1'b0;
  endtask

  task automatic b_wait(input logic [5:0] id);
    bit ok = 0;
    axi_if.req.b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (axi_if.resp.b_valid) begin ok = 1; break; end
    end
    if (!ok) check("b_timeout", 32'(axi_if.resp.b_valid), 32'd1);
    check("b_id", 32'(axi_if.resp.b.id), 32'(id));
    check("b_resp", 32'(axi_if.resp.b.resp), 32'd0);
    @(posedge clk_i);
    #1 axi_if.req.b_ready = 1'b0;
  endtask

  task automatic put_char(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] ch);
    logic [1:0] lane;
    lane = addr[1:0];
    exp_q.push_back({6'd0, addr[9:8], ch});
    aw_send(id, addr, 8'd0);
    w_send(32'(ch) << (8 * lane), 4'b0001 << lane, 1'b1);
    b_wait(id);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_i);
      #2;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int beats;
    bit done;
    axi_if.req   = '0;
    char_ready_i = 1'b0;
    rst_ni       = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_aw_ready", 32'(axi_if.resp.aw_ready), 32'd0);
    check("rst_ar_ready", 32'(axi_if.resp.ar_ready), 32'd0);
    check("rst_w_ready", 32'(axi_if.resp.w_ready), 32'd0);
    check("rst_b_valid", 32'(axi_if.resp.b_valid), 32'd0);
    check("rst_r_valid", 32'(axi_if.resp.r_valid), 32'd0);
    check("rst_char_valid", 32'(char_valid_o), 32'd0);
    check("rst_char_data", 32'(char_data_o), 32'd0);
    check("rst_char_chan", 32'(char_chan_o), 32'd0);
    check("rst_eoc_valid", 32'(eoc_valid_o), 32'd0);
    check("rst_eoc_retval", eoc_retval_o, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step();
    check("idle_aw_ready", 32'(axi_if.resp.aw_ready), 32'd1);
    check("idle_ar_ready", 32'(axi_if.resp.ar_ready), 32'd1);

    // single write: 'A' to channel 1, visible one cycle after the W handshake
    char_ready_i = 1'b1;
    exp_q.push_back({6'd0, 2'd1, 8'h41});
    aw_send(6'd5, 32'h0000_0100, 8'd0);
    w_send(32'h0000_0041, 4'h1, 1'b1);
    @(negedge clk_i);
    check("t1_char_latency", 32'(char_valid_o), 32'd1);
    step();
    b_wait(6'd5);
    drain();

    // 4-beat FIXED burst, lane 2, channel 3, sink stalled
    char_ready_i = 1'b0;
    aw_send(6'd2, 32'h0000_0302, 8'd3);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] ch;
      ch = 8'h61 + 8'(b);
      exp_q.push_back({6'd0, 2'd3, ch});
      w_send(32'(ch) << 16, 4'b0100, (b == 3));
      if (b == 2) check("t2_no_early_b", 32'(axi_if.resp.b_valid), 32'd0);
    end
    b_wait(6'd2);
    check("t2_head_valid", 32'(char_valid_o), 32'd1);
    check("t2_head_data", 32'(char_data_o), 32'h61);
    check("t2_head_chan", 32'(char_chan_o), 32'd3);
    char_ready_i = 1'b1;
    drain();

    // fill the FIFO, then backpressure on the 9th beat until the sink drains
    char_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) put_char(6'(i), 32'h0000_0000, 8'h30 + 8'(i));
    exp_q.push_back({6'd0, 2'd0, 8'h38});
    aw_send(6'd8, 32'h0000_0000, 8'd0);
    axi_if.req.w.data  = 32'h0000_0038;
    axi_if.req.w.strb  = 4'h1;
    axi_if.req.w.last  = 1'b1;
    axi_if.req.w_valid = 1'b1;
    repeat (2) @(negedge clk_i);
    check("t3_backpressure", 32'(axi_if.resp.w_ready), 32'd0);
    check("t3_full_valid", 32'(char_valid_o), 32'd1);
    @(posedge clk_i);
    #1 char_ready_i = 1'b1;
    #1 check("t3_push_pop_full", 32'(axi_if.resp.w_ready), 32'd1);
    w_send(32'h0000_0038, 4'h1, 1'b1);
    b_wait(6'd8);
    put_char(6'd9, 32'h0000_0000, 8'h39);
    drain();

    // end-of-computation: first value sticks
    check("t4_eoc_before", 32'(eoc_valid_o), 32'd0);
    aw_send(6'd7, 32'h0000_F000, 8'd0);
    w_send(32'h0000_0007, 4'hF, 1'b1);
    check("t4_eoc_valid", 32'(eoc_valid_o), 32'd1);
    check("t4_eoc_retval", eoc_retval_o, 32'd7);
    b_wait(6'd7);
    aw_send(6'd9, 32'h0000_F000, 8'd0);
    w_send(32'h0000_0009, 4'hF, 1'b1);
    b_wait(6'd9);
    check("t4_eoc_hold_valid", 32'(eoc_valid_o), 32'd1);
    check("t4_eoc_hold_retval", eoc_retval_o, 32'd7);

    // console beat whose lane strobe is clear pushes nothing
    aw_send(6'd10, 32'h0000_0101, 8'd0);
    w_send(32'h0000_4242, 4'b0001, 1'b1);
    b_wait(6'd10);
    repeat (2) step();
    check("t4_strb_drop", 32'(char_valid_o), 32'd0);

    // concurrent AR (len 2) and AW
    axi_if.req.ar.id    = 6'd3;
    axi_if.req.ar.addr  = 32'h0000_0100;
    axi_if.req.ar.len   = 8'd2;
    axi_if.req.ar_valid = 1'b1;
    axi_if.req.aw.id    = 6'd4;
    axi_if.req.aw.addr  = 32'h0000_0100;
    axi_if.req.aw.len   = 8'd0;
    axi_if.req.aw_valid = 1'b1;
    @(negedge clk_i);
    check("t5_aw_ready", 32'(axi_if.resp.aw_ready), 32'd1);
    check("t5_ar_ready", 32'(axi_if.resp.ar_ready), 32'd1);
    @(posedge clk_i);
    #1;
    axi_if.req.ar_valid = 1'b0;
    axi_if.req.aw_valid = 1'b0;
    axi_if.req.r_ready  = 1'b1;
    beats = 0;
    done  = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_i);
      if (axi_if.resp.r_valid) begin
        check("t5_r_id", 32'(axi_if.resp.r.id), 32'd3);
        check("t5_r_resp", 32'(axi_if.resp.r.resp), 32'd2);
        check("t5_r_data", axi_if.resp.r.data, 32'd0);
        check("t5_r_last", 32'(axi_if.resp.r.last), 32'(beats == 2));
        if (axi_if.resp.r.last) done = 1;
        beats++;
      end
    end
    check("t5_r_beats", 32'(beats), 32'd3);
    step();
    axi_if.req.r_ready = 1'b0;
    check("t5_r_idle", 32'(axi_if.resp.r_valid), 32'd0);
    exp_q.push_back({6'd0, 2'd1, 8'h55});
    w_send(32'h0000_0055, 4'h1, 1'b1);
    b_wait(6'd4);
    drain();

    // reset during beat 2 of a 4-beat burst
    char_ready_i = 1'b0;
    aw_send(6'd6, 32'h0000_0200, 8'd3);
    exp_q.push_back({6'd0, 2'd2, 8'h78});
    w_send(32'h0000_0078, 4'h1, 1'b0);
    axi_if.req.w.data  = 32'h0000_0079;
    axi_if.req.w_valid = 1'b1;
    rst_ni             = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni             = 1'b1;
    axi_if.req.w_valid = 1'b0;
    exp_q.delete();
    check("t6_char_valid", 32'(char_valid_o), 32'd0);
    check("t6_eoc_valid", 32'(eoc_valid_o), 32'd0);
    check("t6_eoc_retval", eoc_retval_o, 32'd0);
    check("t6_w_ready", 32'(axi_if.resp.w_ready), 32'd0);
    repeat (3) step();
    check("t6_no_b", 32'(axi_if.resp.b_valid), 32'd0);
    check("t6_aw_ready", 32'(axi_if.resp.aw_ready), 32'd1);
    char_ready_i = 1'b1;
    put_char(6'd11, 32'h0000_0100, 8'h5A);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mempool_axi_console.md
MEMPOOL_AXI_CONSOLE -- requirements
Module: mempool_axi_console

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, AXI address width.
REQ-002 SHALL have parameter DataWidth, default 32, AXI data width; legal values 32, 64, 128.
REQ-003 SHALL have parameter IdWidth, default 6, AXI ID width.
REQ-004 SHALL have parameter NumChannels, default 4, number of independent console channels; power of two, 1..16.
REQ-005 SHALL have parameter CharFifoDepth, default 8, character FIFO depth; power of two, at least 2.
REQ-006 SHALL have parameter ChanSelLsb, default 8, lowest address bit of the channel-select field.
REQ-007 SHALL have parameter EocOffset, default 32'h0000_F000, address offset decoded as end-of-computation.
REQ-008 SHALL have parameters axi_req_t and axi_resp_t, the AXI request/response struct types.
REQ-009 SHALL have port clk_i, input, 1 bit, clock.
REQ-010 SHALL have port rst_ni, input, 1 bit, reset; synchronous, active-low.
REQ-011 SHALL have port axi_req_i, input, axi_req_t, AXI slave request.
REQ-012 SHALL have port axi_resp_o, output, axi_resp_t, AXI slave response.
REQ-013 SHALL have port char_valid_o, output, 1 bit, character available.
REQ-014 SHALL have port char_data_o, output, 8 bits, character.
REQ-015 SHALL have port char_chan_o, output, max(1,$clog2(NumChannels)) bits, source channel of the character.
REQ-016 SHALL have port char_ready_i, input, 1 bit, sink accepts the character.
REQ-017 SHALL have port eoc_valid_o, output, 1 bit, end-of-computation seen (sticky).
REQ-018 SHALL have port eoc_retval_o, output, 32 bits, return value.

Function
REQ-019 SHALL implement the write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
REQ-020 In W_IDLE: aw_ready=1; on AW handshake, capture id, addr and len (beats = len+1) and go to W_DATA.
REQ-021 In W_DATA: each W handshake decrements the beat counter; on the beat with w.last, or when the counter reaches 0, go to W_RESP.
REQ-022 In W_RESP: b_valid=1, b.id = captured id, b.resp = OKAY; go to W_IDLE when b_ready.
REQ-023 Every burst is treated as FIXED: all beats use the captured address.
REQ-024 Address decode (offset = addr[ChanSelLsb+7:0] relative to bit 0):
  - offset == EocOffset[ChanSelLsb+7:0] -> EOC target.
  - otherwise -> console channel addr[ChanSelLsb +: log2 NumChannels].
REQ-025 Console beat: char = byte lane addr[$clog2(DataWidth/8)-1:0] of w.data; it is pushed with its channel only if that lane's strb bit is set; otherwise the beat is consumed and nothing is pushed.
REQ-026 Console beat with the FIFO full: w_ready=0 (backpressure); the beat is accepted in the same cycle the FIFO gets a free slot.
REQ-027 FIFO push and pop in the same cycle while full are allowed; w_ready=1 in that case.
REQ-028 EOC beat: w_ready=1 unconditionally.
  - First EOC beat: eoc_retval_o <= w.data[31:0] and eoc_valid_o <= 1 in the next cycle.
  - Later EOC beats are ignored but still get an OKAY response.
REQ-029 FIFO: char_valid_o = not empty; a pop occurs on char_valid_o && char_ready_i; strict FIFO order across all channels; latency from W handshake to char_valid_o = 1 cycle.
REQ-030 Read FSM is independent of the write FSM: R_IDLE -> R_DATA.
  - In R_IDLE: ar_ready=1; capture id and len.
  - In R_DATA: return len+1 beats with r.data=0, r.resp=SLVERR, r.id = captured id, and r.last on the final beat.
REQ-031 All ready/valid outputs SHALL be registered or derived only from state and the FIFO count; no combinational path from aw_valid/ar_valid to the corresponding ready.
REQ-032 Simultaneous AW and AR handshakes SHALL both be accepted in the same cycle.
REQ-033 Unused response fields (user, etc.) SHALL be 0.

Reset
REQ-034 While rst_ni=0 at a clk_i edge: both FSMs return to IDLE, the FIFO is emptied, and the beat counters are cleared.
REQ-035 While rst_ni=0 at a clk_i edge: eoc_valid_o=0, eoc_retval_o=0, char_valid_o=0, char_data_o=0, char_chan_o=0.
REQ-036 While rst_ni=0 at a clk_i edge: all AXI valid/ready outputs are 0.
REQ-037 A reset asserted mid-burst SHALL abandon the transaction with no B or R response; the first cycle after reset release is in IDLE.

Verification
REQ-038 Single write, addr 0x0000_0100, data 0x41, strb 0x1, id 5, char_ready_i=1 -> char 0x41 on channel 1 one cycle after the W handshake; B id 5, OKAY.
REQ-039 4-beat burst to addr 0x0000_0302, data lane 2 = 'a','b','c','d', char_ready_i=0 with CharFifoDepth=8 -> 4 chars on channel 3 in order; one B after the last beat.
REQ-040 10 single-beat writes with char_ready_i=0 -> w_ready drops after the 8th push; raise char_ready_i -> beats 9 and 10 complete; 10 pops in order.
REQ-041 EOC write data 0x0000_0007, then EOC write 0x0000_0009 -> eoc_valid_o=1, eoc_retval_o=7 held; both get B OKAY.
REQ-042 AR len=2, id 3 issued concurrently with an AW -> 3 R beats, SLVERR, data 0, r.last on beat 3; write completes unaffected.
REQ-043 rst_ni=0 for one cycle during beat 2 of a 4-beat burst -> no B, FIFO empty, eoc_valid_o=0; next AW accepted normally.
